operand_skew_feeder: RTL and testbench
======================================

OPERAND_SKEW_FEEDER -- requirements
Module: operand_skew_feeder

Interface
REQ-001 Parameter ARR_SIZE, default 4, number of systolic lanes (rows of MAC array).
REQ-002 Parameter DATA_W, default 32, width of one lane operand.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a tile; honoured only in IDLE.
REQ-006 in_valid  input  1  upstream Buffer presents a vector.
REQ-007 in_ready  output  1  feeder accepts the vector this cycle; transfer = in_valid & in_ready.
REQ-008 in_data  input  ARR_SIZE*DATA_W  lane i = bits [i*DATA_W +: DATA_W].
REQ-009 in_last  input  1  qualifies the final vector of the tile; sampled only on transfer.
REQ-010 mac_stall  input  1  downstream MAC cannot advance this cycle.
REQ-011 out_data  output  ARR_SIZE*DATA_W  skewed operands to MAC, same lane packing.
REQ-012 out_valid  output  ARR_SIZE  per-lane valid.
REQ-013 busy  output  1  state != IDLE.
REQ-014 done  output  1  one-cycle pulse when tile fully drained.
REQ-015 vec_count  output  16  vectors accepted in current tile.

Function
REQ-016 States IDLE, STREAM, DRAIN; IDLE --start--> STREAM (vec_count cleared); STREAM --transfer with in_last--> DRAIN; DRAIN --final drain advance--> IDLE.
REQ-017 advance = !mac_stall, in every state; in_ready = (state == STREAM) & advance.
REQ-018 On advance, every lane delay line shifts; lane 0 entry loads transferred data with valid 1, else zero with valid 0 (bubble).
REQ-019 Latency: lane i of a vector accepted in cycle t is visible on out_data/out_valid in cycle t+1+i, absent stalls.
REQ-020 While mac_stall=1: all delay lines, out_data, out_valid, state, counters hold; no transfer.
REQ-021 out_data lane SHALL be zero whenever its out_valid bit is 0.
REQ-022 On the in_last transfer, drain counter loads ARR_SIZE-1; in DRAIN each advance decrements it; advance at zero -> IDLE and done=1 next cycle (cycle t+ARR_SIZE+1 unstalled).
REQ-023 done is a single-cycle pulse, never asserted twice per tile, unaffected by mac_stall in its cycle.
REQ-024 vec_count increments per transfer, saturates at 16'hFFFF, holds after done until next start.
REQ-025 start outside IDLE ignored; in_valid in IDLE/DRAIN not accepted (in_ready=0).
REQ-026 in_last on a STREAM transfer with vec_count=0 (single-vector tile) is legal.

Reset
REQ-027 reset clears state to IDLE, all delay lines, out_data=0, out_valid=0, in_ready=0, busy=0, done=0, vec_count=0, drain counter=0.
REQ-028 reset mid-STREAM/DRAIN discards in-flight data; no done is produced for that tile.
REQ-029 reset has priority over start, transfer and mac_stall in the same cycle.

Structure
REQ-030 Shared package accel_pkg holds DATA_W default, ARR_SIZE default and the feeder state enum.
REQ-031 One sub-module skew_delay_line (parameter DEPTH, DATA_W; ports clk, reset, en, d, d_valid, q, q_valid), instantiated per lane with DEPTH = i+1.
REQ-032 FSM, drain counter and vec_count reside in operand_skew_feeder top.

Verification (ARR_SIZE=4, DATA_W=32)
REQ-033 Assert reset 2 cycles with random inputs -> all outputs 0, busy 0.
REQ-034 start; vector {0x44,0x33,0x22,0x11} (lane3..0) with in_last at cycle t -> lane0=0x11 at t+1, lane1=0x22 at t+2, lane2=0x33 at t+3, lane3=0x44 at t+4, done at t+5, vec_count=1.
REQ-035 Back-to-back v0,v1,v2 at t..t+2, last on v2 -> cycle t+3 out_valid=4'b0111 with lanes 0/1/2 = v2[0]/v1[1]/v0[2]; done at t+7; vec_count=3.
REQ-036 in_valid low one cycle between v0 and v1 -> zero, valid-0 diagonal bubble between wavefronts; done delayed one cycle.
REQ-037 mac_stall high 2 cycles during DRAIN -> outputs hold bit-exact, in_ready 0, done delayed exactly 2 cycles.
REQ-038 reset at second DRAIN cycle -> next cycle busy=0, out_valid=0, no done pulse in following 10 cycles.

Source files
------------

// File: rtl/accel_pkg.sv
// accel_pkg: shared accelerator defaults and the operand feeder state encoding.
package accel_pkg;
   localparam int ACC_ARR_SIZE = 4;
   localparam int ACC_DATA_W   = 32;
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} feeder_state_e;
endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: DEPTH-stage enable-gated shift register carrying one lane operand and its valid.
module skew_delay_line
   import accel_pkg::*;
#(
   parameter int DEPTH  = 1,
   parameter int DATA_W = ACC_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   input  logic              d_valid,
   output logic [DATA_W-1:0] q,
   output logic              q_valid
);
   logic [DATA_W-1:0] data [DEPTH];
   logic [DEPTH-1:0]  valid;
   // Bubbles enter as zero so an invalid output lane is always zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) data[k] <= '0;
         valid <= '0;
      end else if (en) begin
         data[0]  <= d_valid ? d : '0;
         valid[0] <= d_valid;
         for (int k = 1; k < DEPTH; k++) begin
            data[k]  <= data[k-1];
            valid[k] <= valid[k-1];
         end
      end
   end
   assign q       = data[DEPTH-1];
   assign q_valid = valid[DEPTH-1];
endmodule

// File: rtl/operand_skew_feeder.sv
// operand_skew_feeder: accepts operand vectors per tile and skews lane i by i+1 cycles into a systolic MAC array.
module operand_skew_feeder
   import accel_pkg::*;
#(
   parameter int ARR_SIZE = ACC_ARR_SIZE,
   parameter int DATA_W   = ACC_DATA_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ARR_SIZE*DATA_W-1:0] in_data,
   input  logic                       in_last,
   input  logic                       mac_stall,
   output logic [ARR_SIZE*DATA_W-1:0] out_data,
   output logic [ARR_SIZE-1:0]        out_valid,
   output logic                       busy,
   output logic                       done,
   output logic [15:0]                vec_count
);
   localparam int CW = ARR_SIZE > 1 ? $clog2(ARR_SIZE) : 1;
   feeder_state_e state, state_nx;
   logic [CW-1:0] drain_cnt, drain_nx;
   logic [15:0]   count_nx;
   logic          done_nx, advance, xfer;
   assign advance  = !mac_stall;
   assign in_ready = (state == STREAM) && advance;
   assign xfer     = in_valid && in_ready;
   assign busy     = state != IDLE;
   always_comb begin
      state_nx = state;
      drain_nx = drain_cnt;
      count_nx = vec_count;
      done_nx  = 1'b0;
      case (state)
         IDLE: if (start && advance) begin
            state_nx = STREAM;
            count_nx = '0;
         end
         STREAM: if (xfer) begin
            count_nx = (&vec_count) ? vec_count : vec_count + 16'd1;
            if (in_last) begin
               state_nx = DRAIN;
               drain_nx = CW'(ARR_SIZE - 1);
            end
         end
         DRAIN: if (advance) begin
            // The final advance pushes the last lane's operand out of its line.
            if (drain_cnt == '0) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else begin
               drain_nx = drain_cnt - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= '0;
         vec_count <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_nx;
         drain_cnt <= drain_nx;
         vec_count <= count_nx;
         done      <= done_nx;
      end
   end
   for (genvar g = 0; g < ARR_SIZE; g++) begin : g_lane
      skew_delay_line #(.DEPTH(g + 1), .DATA_W(DATA_W)) u_line (
         .clk    (clk),
         .reset  (reset),
         .en     (advance),
         .d      (in_data[g*DATA_W +: DATA_W]),
         .d_valid(xfer),
         .q      (out_data[g*DATA_W +: DATA_W]),
         .q_valid(out_valid[g])
      );
   end
endmodule

// File: tb/tb_operand_skew_feeder.sv
// tb_operand_skew_feeder: directed tiles checked against a tick-history model plus literal expectations.
module tb_operand_skew_feeder;
   localparam int A = 4;
   localparam int W = 32;
   localparam int B = A * W;
   logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, mac_stall = 0;
   logic [B-1:0] in_data = '0;
   logic in_ready, busy, done;
   logic [B-1:0] out_data;
   logic [A-1:0] out_valid;
   logic [15:0] vec_count;
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   operand_skew_feeder #(.ARR_SIZE(A), .DATA_W(W)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .mac_stall(mac_stall), .out_data(out_data),
      .out_valid(out_valid), .busy(busy), .done(done), .vec_count(vec_count)
   );
   task automatic chk(input string name, input logic [B-1:0] got, input logic [B-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask
   // Model: every unstalled edge is one tick; a vector accepted at tick k shows lane i at tick k+1+i.
   typedef enum {M_IDLE, M_STREAM, M_DRAIN} mode_e;
   mode_e mode = M_IDLE;
   int tick = 0, floor_t = 0, last_k = 0;
   logic [15:0] m_cnt = '0;
   bit m_done = 0, armed = 0;
   logic [B-1:0] hist_d [int];
   bit hist_v [int];
   always @(posedge clk) begin
      mode_e m0;
      m0 = mode;
      m_done = 0;
      if (reset) begin
         armed = 1;
         mode = M_IDLE;
         m_cnt = '0;
         floor_t = tick;
      end else if (!mac_stall) begin
         hist_v[tick] = (m0 == M_STREAM) && in_valid;
         hist_d[tick] = in_data;
         if (hist_v[tick]) begin
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            if (in_last) begin
               mode = M_DRAIN;
               last_k = tick;
            end
         end
         if (m0 == M_IDLE && start) begin
            mode = M_STREAM;
            m_cnt = '0;
         end
         tick++;
         if (m0 == M_DRAIN && tick == last_k + A + 1) begin
            mode = M_IDLE;
            m_done = 1;
         end
      end
   end
   always @(posedge clk) begin
      logic [B-1:0] ed, h;
      logic [A-1:0] ev;
      #1;
      if (armed) begin
         ed = '0;
         ev = '0;
         for (int i = 0; i < A; i++) begin
            int idx;
            idx = tick - 1 - i;
            if (idx >= floor_t && hist_v.exists(idx) && hist_v[idx]) begin
               h = hist_d[idx];
               ev[i] = 1'b1;
               ed[i*W +: W] = h[i*W +: W];
            end
         end
         chk("m_out_data", out_data, ed);
         chk("m_out_valid", B'(out_valid), B'(ev));
         chk("m_in_ready", B'(in_ready), B'(mode == M_STREAM && !mac_stall));
         chk("m_busy", B'(busy), B'(mode != M_IDLE));
         chk("m_done", B'(done), B'(m_done));
         chk("m_vec_count", B'(vec_count), B'(m_cnt));
      end
   end
   task automatic step();
      @(posedge clk);
      #2;
   endtask
   task automatic drv(input bit s, input bit v, input bit l, input bit st, input logic [B-1:0] d);
      @(negedge clk);
      start = s;
      in_valid = v;
      in_last = l;
      mac_stall = st;
      in_data = d;
   endtask
   task automatic idle();
      drv(0, 0, 0, 0, '0);
   endtask
   task automatic wait_done(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!done && n < 50);
   endtask
   function automatic logic [W-1:0] lane(input logic [B-1:0] v, input int i);
      return v[i*W +: W];
   endfunction
   initial begin
      int n;
      logic [B-1:0] v0, v1, v2;
      repeat (2) begin
         drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom});
         step();
      end
      chk("rst_out_data", out_data, '0);
      chk("rst_out_valid", B'(out_valid), '0);
      chk("rst_busy", B'(busy), '0);
      chk("rst_done", B'(done), '0);
      chk("rst_vec_count", B'(vec_count), '0);
      chk("rst_in_ready", B'(in_ready), '0);
      idle();
      reset = 0;
      // single-vector tile
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 1, 0, {32'h44, 32'h33, 32'h22, 32'h11});
      for (int i = 0; i < A; i++) begin
         step();
         chk("t1_lane", B'(lane(out_data, i)), B'(32'h11 * (i + 1)));
         chk("t1_valid", B'(out_valid), B'(1 << i));
         idle();
      end
      step();
      chk("t1_done", B'(done), B'(1));
      chk("t1_count", B'(vec_count), B'(1));
      // back-to-back three vectors, start inside STREAM is ignored
      v0 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      v1 = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
      v2 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
      idle();
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 0, 0, v0);
      drv(1, 1, 0, 0, v1);
      drv(0, 1, 1, 0, v2);
      step();
      chk("t2_valid", B'(out_valid), B'(4'b0111));
      chk("t2_lane0", B'(lane(out_data, 0)), B'(32'hC0));
      chk("t2_lane1", B'(lane(out_data, 1)), B'(32'hB1));
      chk("t2_lane2", B'(lane(out_data, 2)), B'(32'hA2));
      chk("t2_lane3", B'(lane(out_data, 3)), '0);
      drv(0, 1, 0, 0, {4{32'hFFFF_FFFF}});
      wait_done(n);
      chk("t2_done_lat", B'(n), B'(4));
      chk("t2_count", B'(vec_count), B'(3));
      // one-cycle gap gives a zero bubble diagonal
      v1 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      idle();
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 0, 0, v0);
      idle();
      step();
      chk("t3_gap_valid", B'(out_valid), B'(4'b0010));
      chk("t3_gap_lane0", B'(lane(out_data, 0)), '0);
      drv(0, 1, 1, 0, v1);
      step();
      chk("t3_valid", B'(out_valid), B'(4'b0101));
      chk("t3_lane0", B'(lane(out_data, 0)), B'(32'hD0));
      chk("t3_lane1", B'(lane(out_data, 1)), '0);
      chk("t3_lane2", B'(lane(out_data, 2)), B'(32'hA2));
      idle();
      wait_done(n);
      chk("t3_done_lat", B'(n), B'(4));
      chk("t3_count", B'(vec_count), B'(2));
      // two stalled cycles in DRAIN
      v2 = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
      idle();
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 1, 0, v2);
      step();
      idle();
      step();
      chk("t4_pre_valid", B'(out_valid), B'(4'b0010));
      for (int i = 0; i < 2; i++) begin
         drv(0, 1, 0, 1, {4{32'h5A5A_5A5A}});
         step();
         chk("t4_hold_valid", B'(out_valid), B'(4'b0010));
         chk("t4_hold_lane1", B'(lane(out_data, 1)), B'(32'hE1));
         chk("t4_ready", B'(in_ready), '0);
      end
      idle();
      wait_done(n);
      chk("t4_done_lat", B'(n), B'(3));
      // reset in the second DRAIN cycle
      idle();
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 1, 0, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
      step();
      idle();
      step();
      idle();
      reset = 1;
      step();
      chk("t5_busy", B'(busy), '0);
      chk("t5_valid", B'(out_valid), '0);
      idle();
      reset = 0;
      n = 0;
      repeat (10) begin
         step();
         if (done) n++;
      end
      chk("t5_no_done", B'(n), '0);
      // stall blocks a transfer in STREAM
      drv(1, 0, 0, 0, '0);
      drv(0, 1, 0, 1, {4{32'h1234_5678}});
      drv(0, 1, 1, 0, {4{32'h8765_4321}});
      wait_done(n);
      chk("t6_done_lat", B'(n), B'(5));
      chk("t6_count", B'(vec_count), B'(1));
      idle();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
